axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Upstream AXI-Lite master that turns simple single-word commands from a local controller into AXI-Lite transactions towards the AXI-to-SPI peripheral (AW/W/AR/R channels; the peripheral has no B channel). It accepts one command at a time, drives the address/data handshakes, and returns one response per command. A per-transaction timeout reports an error response for a stalled transaction.

## Interface
- TIMEOUT_CYCLES, 1000: max cycles from command acceptance to completion; 0 disables; range 0..65535
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address, passed through unchanged
- cmd_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  echo of cmd_write
- rsp_err  out  1  1 = transaction timed out
- rsp_rdata  out  32  read data (0 for writes and errors)
- AWVALID out 1, AWREADY in 1, AWADDR out 32
- WVALID out 1, WREADY in 1, WDATA out 32
- ARVALID out 1, ARREADY in 1, ARADDR out 32
- RVALID in 1, RREADY out 1, RDATA in 32

## Operation
- States: IDLE, WR, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1 (only state where it is 1). On accept, latch cmd_write/addr/wdata, clear timeout counter; go WR (write) or RD_ADDR (read).
- WR: AWVALID and WVALID both 1 on entry; each drops independently after its own handshake (VALID&READY at an edge). AW and W may complete in the same or different cycles, in either order. When both done -> RESP, rsp_err=0, rsp_rdata=0.
- RD_ADDR: ARVALID=1 until ARREADY handshake -> RD_DATA.
- RD_DATA: RREADY=1; on RVALID capture RDATA into rsp_rdata -> RESP, rsp_err=0.
- RESP: rsp_valid=1, rsp fields stable until rsp_ready; then -> IDLE.
- AWADDR/ARADDR = latched address, WDATA = latched data; stable while corresponding VALID is 1.
- Timeout: 16-bit counter increments every cycle in WR/RD_ADDR/RD_DATA. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with transaction still incomplete at that edge, deassert all VALID/RREADY, go RESP with rsp_err=1, rsp_rdata=0. A handshake completing on that same edge wins (normal response, no error).
- No pipelining: a new command is not accepted until the previous response is consumed.

## Timing
- Reset (async assert, sync release via ARESETn): state IDLE; cmd_ready=1; rsp_valid=0, rsp_write=0, rsp_err=0, rsp_rdata=0; AWVALID=WVALID=ARVALID=RREADY=0; AWADDR=WDATA=ARADDR=0. Reset mid-transaction abandons it; no response is produced.
- Command accepted at edge 0 -> AWVALID/WVALID or ARVALID high in cycle 1.
- Write, slave ready immediately: handshake edge 1, rsp_valid in cycle 2 (2-cycle latency).
- Read, slave ready immediately, RVALID one cycle after AR: AR handshake edge 1, RREADY high cycle 2, R handshake edge 2, rsp_valid cycle 3.
- rsp_ready held high: rsp_valid lasts exactly 1 cycle; cmd_ready returns the following cycle.
- RVALID asserted while not in RD_DATA is ignored (RREADY=0).

## Test plan
- Write 0xA5A5_0001 to 0x0000_0004, AWREADY/WREADY tied 1 -> AWADDR=4, WDATA=0xA5A50001 for one cycle, rsp_valid cycle 2, rsp_write=1, rsp_err=0.
- Write with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID stays until WREADY, single response after W handshake.
- Read 0x0000_000C, ARREADY after 2 cycles, RVALID with RDATA=0x1234_5678 2 cycles later -> rsp_rdata=0x12345678, rsp_write=0, rsp_err=0.
- TIMEOUT_CYCLES=8, ARREADY never asserted -> ARVALID drops, rsp_valid with rsp_err=1, rsp_rdata=0, exactly 8 cycles after accept edge.
- rsp_ready held 0 for 5 cycles -> rsp fields stable, cmd_ready=0, second cmd_valid not accepted until response consumed.
- ARESETn pulsed low mid-WR -> all outputs immediately at reset values, no response; next command completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: one local command in, one AW/W or AR/R
// transaction out, one response back, with an optional per-transaction timeout.
module axi_lite_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] AWADDR,
    output logic        WVALID,
    input  logic        WREADY,
    output logic [31:0] WDATA,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [31:0] RDATA
);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RESP} state_e;

    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] CNT_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [15:0] cnt_q, cnt_d;

    logic expired;
    logic aw_left;
    logic w_left;

    // A handshake on the expiry edge still completes normally, so expiry is
    // only consulted after the completion conditions below.
    assign expired = TO_EN && (cnt_q == CNT_LAST);
    assign aw_left = aw_pend_q & ~AWREADY;
    assign w_left  = w_pend_q & ~WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        write_d   = write_q;
        err_d     = err_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (cmd_write) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR: begin
                cnt_d     = cnt_q + 16'd1;
                aw_pend_d = aw_left;
                w_pend_d  = w_left;
                if (!aw_left && !w_left) begin
                    state_d = RESP;
                end else if (expired) begin
                    aw_pend_d = 1'b0;
                    w_pend_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end
            end
            RD_ADDR: begin
                cnt_d = cnt_q + 16'd1;
                if (ARREADY) begin
                    state_d = RD_DATA;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RD_DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (RVALID) begin
                    rdata_d = RDATA;
                    state_d = RESP;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        AWVALID   = (state_q == WR) && aw_pend_q;
        WVALID    = (state_q == WR) && w_pend_q;
        ARVALID   = (state_q == RD_ADDR);
        RREADY    = (state_q == RD_DATA);
    end

    assign rsp_write = write_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: a vector table of single commands with
// scripted slave delays, plus sequences for back-pressure, idle RVALID and reset.
module tb_axi_lite_cmd_master;

    localparam int T = 8;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;

    int checks = 0;
    int errors = 0;

    axi_lite_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        int          hold;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   c;
        logic ok;
        logic hold_ok;
        logic awv, wv, arv, rr;
        $display("vec %0d: wr=%0d addr=%h wdata=%h exp_lat=%0d exp_err=%0d exp_rdata=%h",
                 idx, v.wr, v.addr, v.wdata, v.exp_lat, v.exp_err, v.exp_rdata);
        @(negedge ACLK);
        check($sformatf("v%0d_cmd_ready", idx), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = 1'b0;
        @(posedge ACLK);
        ok = 1'b1;
        for (int e = 0; e < v.exp_lat; e++) begin
            @(negedge ACLK);
            cmd_valid = 1'b0;
            c = e + 1;
            awv = v.wr && (c <= v.aw_dly + 1);
            wv  = v.wr && (c <= v.w_dly + 1);
            arv = !v.wr && (c <= v.ar_dly + 1);
            rr  = !v.wr && (c > v.ar_dly + 1);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) ok = 1'b0;
            if (AWVALID !== awv || WVALID !== wv || ARVALID !== arv || RREADY !== rr) ok = 1'b0;
            if (AWVALID && AWADDR !== v.addr) ok = 1'b0;
            if (WVALID && WDATA !== v.wdata) ok = 1'b0;
            if (ARVALID && ARADDR !== v.addr) ok = 1'b0;
            AWREADY = v.wr && (c > v.aw_dly);
            WREADY  = v.wr && (c > v.w_dly);
            ARREADY = !v.wr && (c > v.ar_dly);
            RVALID  = !v.wr && (c >= v.ar_dly + 1 + v.r_dly);
            RDATA   = RVALID ? v.rdata : 32'hDEAD0000;
        end
        @(negedge ACLK);
        cmd_valid = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0;
        check($sformatf("v%0d_channels", idx), {31'd0, ok}, 32'd1);
        check($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("v%0d_rsp_write", idx), {31'd0, rsp_write}, {31'd0, v.wr});
        check($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
        check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_valids_in_resp", idx),
              {28'd0, AWVALID, WVALID, ARVALID, RREADY}, 32'd0);
        if (v.hold > 0) begin
            hold_ok = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge ACLK);
                if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_write !== v.wr ||
                    rsp_err !== v.exp_err || rsp_rdata !== v.exp_rdata) hold_ok = 1'b0;
            end
            check($sformatf("v%0d_hold_stable", idx), {31'd0, hold_ok}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        rsp_ready = 1'b0;
        check($sformatf("v%0d_release", idx), {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    initial begin
        logic ok;
        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;

        //          wr    addr          wdata         aw   w    ar   r    rdata         hold lat err   exp_rdata
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 0,   0,   100, 1,   32'h0,         0,   1,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0,   3,   100, 1,   32'h0,         0,   4,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_000C, 32'h0,         100, 100, 2,   2,   32'h1234_5678, 0,   5,  1'b0, 32'h1234_5678};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0F0F_F0F0, 4,   1,   100, 1,   32'h0,         0,   5,  1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         100, 100, 0,   1,   32'hCAFE_F00D, 0,   2,  1'b0, 32'hCAFE_F00D};
        vecs[5]  = '{1'b1, 32'h0000_0024, 32'h0000_0001, 0,   0,   100, 1,   32'h0,         5,   1,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0030, 32'h0,         100, 100, 100, 1,   32'h0,         0,   8,  1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0034, 32'h0,         100, 100, 0,   7,   32'h0BAD_CAFE, 0,   8,  1'b0, 32'h0BAD_CAFE};
        vecs[8]  = '{1'b1, 32'h0000_0038, 32'h3838_3838, 0,   7,   100, 1,   32'h0,         0,   8,  1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'h3C3C_3C3C, 8,   0,   100, 1,   32'h0,         0,   8,  1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0040, 32'h0,         100, 100, 3,   1,   32'h55AA_55AA, 0,   5,  1'b0, 32'h55AA_55AA};

        repeat (2) @(negedge ACLK);
        check("reset_ctrl", {24'd0, AWVALID, WVALID, ARVALID, RREADY, rsp_valid, rsp_write, rsp_err, cmd_ready},
              32'b0000_0001);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_addr", AWADDR | ARADDR | WDATA, 32'h0);
        ARESETn = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Second command must wait until the pending response is consumed.
        $display("seq blocked_cmd");
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h0000_0011;
        AWREADY = 1'b1; WREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        AWREADY = 1'b0; WREADY = 1'b0;
        check("blk_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0054;
        ok = 1'b1;
        for (int h = 0; h < 5; h++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || ARVALID !== 1'b0 || rsp_write !== 1'b1) ok = 1'b0;
            @(negedge ACLK);
        end
        check("blk_held", {31'd0, ok}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        rsp_ready = 1'b0;
        check("blk_after_consume", {30'd0, rsp_valid, cmd_ready}, 32'b01);
        ARREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        check("blk_arvalid", {31'd0, ARVALID}, 32'd1);
        check("blk_araddr", ARADDR, 32'h0000_0054);
        @(negedge ACLK);
        ARREADY = 1'b0;
        check("blk_rready", {31'd0, RREADY}, 32'd1);
        RVALID = 1'b1; RDATA = 32'h600D_F00D;
        @(negedge ACLK);
        RVALID = 1'b0; RDATA = 32'h0;
        check("blk_read_rsp", {30'd0, rsp_valid, rsp_write}, 32'b10);
        check("blk_read_rdata", rsp_rdata, 32'h600D_F00D);
        rsp_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        rsp_ready = 1'b0;

        // RVALID while idle must be ignored.
        $display("seq idle_rvalid");
        RVALID = 1'b1; RDATA = 32'hBAAD_BAAD;
        ok = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge ACLK);
            if (RREADY !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
        end
        RVALID = 1'b0; RDATA = 32'h0;
        check("idle_rvalid_ignored", {31'd0, ok}, 32'd1);

        // Reset mid-write abandons the transaction.
        $display("seq reset_mid_wr");
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0060; cmd_wdata = 32'h0000_0077;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        check("pre_rst_valids", {30'd0, AWVALID, WVALID}, 32'b11);
        #2 ARESETn = 1'b0;
        #1;
        check("rst_ctrl", {24'd0, AWVALID, WVALID, ARVALID, RREADY, rsp_valid, rsp_write, rsp_err, cmd_ready},
              32'b0000_0001);
        check("rst_data", AWADDR | WDATA | ARADDR | rsp_rdata, 32'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        ok = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
        end
        check("post_rst_no_rsp", {31'd0, ok}, 32'd1);
        run_vec(vecs[0], 11);
        run_vec(vecs[4], 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
